// File: rtl/conv_postproc.sv
// conv_postproc: post-processing stage behind the 3x3 systolic convolution engine.
// Drops line-buffer warm-up border results, requantises the kept accumulators
// (round, arithmetic shift, optional ReLU, saturate to 8 bits) and buffers them
// in a first-word-fall-through FIFO with a ready/valid output and end-of-frame tag.
// Optional build macro: CONV_POSTPROC_STATS_EN adds the sat_count output.
module conv_postproc #(
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32,
   parameter int ACC_WIDTH  = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic signed [ACC_WIDTH-1:0]   in_acc,
   input  logic [4:0]                    cfg_shift,
   input  logic                          cfg_relu,
   input  logic                          clr_ovf,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    out_data,
   output logic                          out_last,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
`ifdef CONV_POSTPROC_STATS_EN
   ,
   output logic [15:0]                   sat_count
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = ACC_WIDTH + 1;

   localparam logic signed [TW-1:0] U8_MAX = TW'(255);
   localparam logic signed [TW-1:0] S8_MAX = TW'(127);
   localparam logic signed [TW-1:0] S8_MIN = TW'(-128);

   logic [CW-1:0]          colCnt_q, colCnt_d;
   logic [RW-1:0]          rowCnt_q, rowCnt_d;
   logic                   colWrap, rowWrap, frameStart, keepPix, lastPix;
   logic [4:0]             shift_q;
   logic                   relu_q;
   logic signed [TW-1:0]   accExt, roundK, sumT, shifted_d;
   logic                   s1Valid_q, s1Last_q, s1Relu_q;
   logic signed [TW-1:0]   s1Val_q;
   logic [7:0]             clamp_d;
   logic                   s2Valid_q, s2Last_q;
   logic [7:0]             s2Data_q;
   logic [8:0]             mem_q [FIFO_DEPTH];
   logic [8:0]             headEntry;
   logic [AW-1:0]          wrPtr_q, rdPtr_q;
   logic [LW-1:0]          level_q, level_d;
   logic                   fifoFull, popEn, pushEn, dropEn;
   logic                   ovf_q;

   assign colWrap    = (colCnt_q == CW'(IMG_WIDTH - 1));
   assign rowWrap    = (rowCnt_q == RW'(IMG_HEIGHT - 1));
   assign frameStart = in_valid && (colCnt_q == '0) && (rowCnt_q == '0);
   assign keepPix    = (rowCnt_q >= RW'(2)) && (colCnt_q >= CW'(2));
   assign lastPix    = rowWrap && colWrap;

   // Next raster position; the counters only move when the engine delivers a result
   always_comb begin
      colCnt_d = colCnt_q;
      rowCnt_d = rowCnt_q;
      if (in_valid) begin
         if (colWrap) begin
            colCnt_d = '0;
            rowCnt_d = rowWrap ? '0 : rowCnt_q + RW'(1);
         end else begin
            colCnt_d = colCnt_q + CW'(1);
         end
      end
   end

   // Raster position registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         colCnt_q <= '0;
         rowCnt_q <= '0;
      end else begin
         colCnt_q <= colCnt_d;
         rowCnt_q <= rowCnt_d;
      end
   end

   // Frame-wide config snapshot taken with the first pixel so a frame never mixes settings
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         relu_q  <= 1'b0;
      end else if (frameStart) begin
         shift_q <= cfg_shift;
         relu_q  <= cfg_relu;
      end
   end

   // One extra bit of headroom so adding the rounding constant can never wrap
   assign accExt    = {in_acc[ACC_WIDTH-1], in_acc};
   assign roundK    = (shift_q == 5'd0) ? '0 : (TW'(1) << (shift_q - 5'd1));
   assign sumT      = accExt + roundK;
   assign shifted_d = sumT >>> shift_q;

   // Stage 1: rounded and shifted value plus its keep/last tags and the frame's ReLU mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q <= 1'b0;
         s1Last_q  <= 1'b0;
         s1Relu_q  <= 1'b0;
         s1Val_q   <= '0;
      end else begin
         s1Valid_q <= in_valid && keepPix;
         s1Last_q  <= lastPix;
         s1Relu_q  <= relu_q;
         s1Val_q   <= shifted_d;
      end
   end

   // Saturate to unsigned 0..255 under ReLU, otherwise to signed int8
   always_comb begin
      clamp_d = s1Val_q[7:0];
      if (s1Relu_q) begin
         if (s1Val_q[TW-1])          clamp_d = 8'h00;
         else if (s1Val_q > U8_MAX)  clamp_d = 8'hFF;
      end else begin
         if (s1Val_q < S8_MIN)       clamp_d = 8'h80;
         else if (s1Val_q > S8_MAX)  clamp_d = 8'h7F;
      end
   end

   // Stage 2: final 8-bit pixel waiting to be written into the FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2Valid_q <= 1'b0;
         s2Last_q  <= 1'b0;
         s2Data_q  <= '0;
      end else begin
         s2Valid_q <= s1Valid_q;
         s2Last_q  <= s1Last_q;
         s2Data_q  <= clamp_d;
      end
   end

   // A full FIFO can still take a write when the consumer pops the head in the same cycle
   assign fifoFull = (level_q == LW'(FIFO_DEPTH));
   assign popEn    = out_valid && out_ready;
   assign pushEn   = s2Valid_q && (!fifoFull || popEn);
   assign dropEn   = s2Valid_q && fifoFull && !popEn;

   // Occupancy after this cycle's push and pop
   always_comb begin
      level_d = level_q + LW'(pushEn) - LW'(popEn);
   end

   // FIFO storage; contents are only observable through the valid head, so no reset
   always_ff @(posedge clk) begin
      if (pushEn) mem_q[wrPtr_q] <= {s2Last_q, s2Data_q};
   end

   // FIFO pointers and occupancy; pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (pushEn) wrPtr_q <= wrPtr_q + AW'(1);
         if (popEn)  rdPtr_q <= rdPtr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear request wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ovf_q <= 1'b0;
      else if (dropEn)  ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
   end

   assign headEntry  = mem_q[rdPtr_q];
   assign out_valid  = (level_q != '0);
   assign out_data   = out_valid ? headEntry[7:0] : 8'h00;
   assign out_last   = out_valid ? headEntry[8]   : 1'b0;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;

`ifdef CONV_POSTPROC_STATS_EN
   logic        s1Clamped;
   logic [15:0] satCnt_q;

   assign s1Clamped = s1Relu_q ? (s1Val_q[TW-1] || (s1Val_q > U8_MAX))
                               : ((s1Val_q < S8_MIN) || (s1Val_q > S8_MAX));

   // Per-frame count of clamped kept pixels, pinned at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         satCnt_q <= '0;
      else if (frameStart)
         satCnt_q <= '0;
      else if (s1Valid_q && s1Clamped && (satCnt_q != 16'hFFFF))
         satCnt_q <= satCnt_q + 16'd1;
   end

   assign sat_count = satCnt_q;
`endif

endmodule

// File: tb/tb_conv_postproc.sv
// tb_conv_postproc: self-checking bench for conv_postproc on a 4x4 image with a 4-deep FIFO.
module tb_conv_postproc;

   localparam int W     = 4;
   localparam int H     = 4;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic signed [31:0] in_acc;
   logic [4:0]         cfg_shift;
   logic               cfg_relu;
   logic               clr_ovf;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_data;
   logic               out_last;
   logic [LW-1:0]      fifo_level;
   logic               overflow;
`ifdef CONV_POSTPROC_STATS_EN
   logic [15:0]        sat_count;
`endif

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic       v;
      logic       last;
      logic [7:0] data;
   } pipeT;

   pipeT       md1, md2;
   logic [8:0] mq[$];
   logic [8:0] gotQ[$];
   bit         mOvf;
   int         mIdx;
   int         mShift;
   bit         mRelu;
   bit         popping, dropped;
   int         cycleCnt = 0;
   bit         prevValid = 1'b0;
   logic [8:0] prevHead = '0;
   bit         armed = 1'b0;
   int         firstValidCycle = -1;
   int         firstKeptCycle = -1;

   conv_postproc #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .ACC_WIDTH (32),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_acc    (in_acc),
      .cfg_shift (cfg_shift),
      .cfg_relu  (cfg_relu),
      .clr_ovf   (clr_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .fifo_level(fifo_level),
      .overflow  (overflow)
`ifdef CONV_POSTPROC_STATS_EN
      ,
      .sat_count (sat_count)
`endif
   );

   always #5 clk = ~clk;

   // Requantisation rule in plain 64-bit arithmetic
   function automatic logic [7:0] requant(input longint acc, input int sh, input bit relu);
      longint t;
      t = acc;
      if (sh > 0) t = t + (longint'(1) << (sh - 1));
      t = t >>> sh;
      if (relu) begin
         if (t < 0)   return 8'h00;
         if (t > 255) return 8'hFF;
         return t[7:0];
      end
      if (t < -128) return 8'h80;
      if (t > 127)  return 8'h7F;
      return t[7:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit v, input logic signed [31:0] acc);
      @(negedge clk);
      in_valid = v;
      in_acc   = acc;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 32'sd0);
   endtask

   // One full frame: border pixels carry their index, kept pixels carry k0..k3 in raster order
   task automatic sendFrameKept(input int k0, input int k1, input int k2, input int k3);
      int kv[4];
      int j;
      kv[0] = k0; kv[1] = k1; kv[2] = k2; kv[3] = k3;
      j = 0;
      for (int i = 0; i < W * H; i++) begin
         if ((i / W >= 2) && (i % W >= 2)) begin
            applyStimulus(1'b1, kv[j]);
            if (j == 0 && firstKeptCycle < 0) firstKeptCycle = cycleCnt + 1;
            j++;
         end else begin
            applyStimulus(1'b1, i);
         end
      end
   endtask

   // Reference model: raster index, per-frame config, two-cycle delay line and bounded queue
   always @(posedge clk) begin
      cycleCnt++;
      if (rst_n && prevValid && out_ready) gotQ.push_back(prevHead);
      if (!rst_n) begin
         mq.delete();
         md1 = '0;
         md2 = '0;
         mOvf = 1'b0;
         mIdx = 0;
         mShift = 0;
         mRelu = 1'b0;
      end else begin
         popping = (mq.size() != 0) && out_ready;
         dropped = 1'b0;
         if (popping) void'(mq.pop_front());
         if (md2.v) begin
            if (mq.size() < DEPTH) mq.push_back({md2.last, md2.data});
            else dropped = 1'b1;
         end
         if (dropped)      mOvf = 1'b1;
         else if (clr_ovf) mOvf = 1'b0;
         md2 = md1;
         md1 = '0;
         if (in_valid) begin
            if (mIdx == 0) begin
               mShift = cfg_shift;
               mRelu  = cfg_relu;
            end
            md1.v    = (mIdx / W >= 2) && (mIdx % W >= 2);
            md1.last = (mIdx == W * H - 1);
            md1.data = requant(in_acc, mShift, mRelu);
            mIdx     = (mIdx + 1) % (W * H);
         end
      end
      #1;
      checkOutput("out_valid", out_valid, mq.size() != 0);
      checkOutput("fifo_level", fifo_level, mq.size());
      checkOutput("overflow", overflow, mOvf);
      if (mq.size() != 0) begin
         checkOutput("out_data", out_data, mq[0][7:0]);
         checkOutput("out_last", out_last, mq[0][8]);
      end
      prevValid = out_valid;
      prevHead  = {out_last, out_data};
      if (armed && out_valid && firstValidCycle < 0) firstValidCycle = cycleCnt + 1;
   end

   initial begin
      logic [7:0] expA[4];
      rst_n = 1'b0; in_valid = 1'b0; in_acc = '0;
      cfg_shift = 5'd0; cfg_relu = 1'b1; clr_ovf = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_data", out_data, 0);
      checkOutput("reset out_last", out_last, 0);
      checkOutput("reset fifo_level", fifo_level, 0);
      checkOutput("reset overflow", overflow, 0);
      rst_n = 1'b1;

      // Raster 0..15, border removal, last tag and fall-through latency
      gotQ.delete(); armed = 1'b1; firstValidCycle = -1; firstKeptCycle = -1;
      sendFrameKept(10, 11, 14, 15);
      idle(6);
      armed = 1'b0;
      checkOutput("A count", gotQ.size(), 4);
      expA[0] = 8'd10; expA[1] = 8'd11; expA[2] = 8'd14; expA[3] = 8'd15;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("A data%0d", i), gotQ[i][7:0], expA[i]);
         checkOutput($sformatf("A last%0d", i), gotQ[i][8], (i == 3) ? 1 : 0);
      end
      checkOutput("A latency", firstValidCycle, firstKeptCycle + 3);

      // Signed rounding and int8 saturation
      cfg_shift = 5'd4; cfg_relu = 1'b0; gotQ.delete();
      sendFrameKept(24, -24, 4000, -5000);
      idle(6);
      checkOutput("B data0", gotQ[0][7:0], 8'h02);
      checkOutput("B data1", gotQ[1][7:0], 8'hFF);
      checkOutput("B data2", gotQ[2][7:0], 8'h7F);
      checkOutput("B data3", gotQ[3][7:0], 8'h80);

      // ReLU clamping
      cfg_shift = 5'd0; cfg_relu = 1'b1; gotQ.delete();
      sendFrameKept(-7, 300, 255, 100);
      idle(6);
      checkOutput("C data0", gotQ[0][7:0], 8'd0);
      checkOutput("C data1", gotQ[1][7:0], 8'd255);
      checkOutput("C data2", gotQ[2][7:0], 8'd255);
      checkOutput("C data3", gotQ[3][7:0], 8'd100);

      // Overflow with a stalled consumer, then clear
      cfg_relu = 1'b0; out_ready = 1'b0;
      sendFrameKept(1, 2, 3, 4);
      sendFrameKept(5, 6, 7, 8);
      idle(4);
      checkOutput("D level full", fifo_level, 4);
      checkOutput("D overflow set", overflow, 1);
      checkOutput("D head intact", out_data, 8'd1);
      clr_ovf = 1'b1;
      idle(1);
      clr_ovf = 1'b0;
      checkOutput("D overflow cleared", overflow, 0);

      // Write into a full FIFO while the head is popped in the same cycle
      for (int i = 0; i <= 10; i++) applyStimulus(1'b1, (i == 10) ? 100 : i);
      idle(1);
      idle(1);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      checkOutput("E level kept", fifo_level, 4);
      checkOutput("E no overflow", overflow, 0);
      gotQ.delete(); out_ready = 1'b1;
      for (int i = 11; i < W * H; i++) applyStimulus(1'b1, i);
      idle(8);
      checkOutput("E drain0", gotQ[0][7:0], 8'd2);
      checkOutput("E drain1", gotQ[1][7:0], 8'd3);
      checkOutput("E drain2", gotQ[2][7:0], 8'd4);
      checkOutput("E drain3", gotQ[3][7:0], 8'd100);

      // Mid-frame shift change only takes effect on the next frame
      cfg_shift = 5'd0; gotQ.delete();
      for (int i = 0; i < W * H; i++) begin
         if (i == 6) cfg_shift = 5'd3;
         applyStimulus(1'b1, ((i / W >= 2) && (i % W >= 2)) ? 20 : i);
      end
      sendFrameKept(20, 20, 20, 20);
      idle(6);
      checkOutput("F count", gotQ.size(), 8);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("F data%0d", i), gotQ[i][7:0], (i < 4) ? 8'd20 : 8'd3);

      // Reset in the middle of a frame restarts the raster
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, i);
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      checkOutput("G reset out_valid", out_valid, 0);
      checkOutput("G reset level", fifo_level, 0);
      idle(2);
      rst_n = 1'b1; out_ready = 1'b1; gotQ.delete();
      sendFrameKept(10, 11, 14, 15);
      idle(6);
      checkOutput("G data0", gotQ[0][7:0], 8'd1);
      checkOutput("G data1", gotQ[1][7:0], 8'd1);
      checkOutput("G data2", gotQ[2][7:0], 8'd2);
      checkOutput("G data3", gotQ[3][7:0], 8'd2);

      // Randomised traffic: gaps, backpressure, config changes and overflow clears
      for (int n = 0; n < 800; n++) begin
         logic signed [31:0] acc;
         if ($urandom_range(0, 19) == 0) cfg_shift = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 19) == 0) cfg_relu  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         clr_ovf   = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 1) == 1) acc = $urandom;
         else                          acc = $urandom_range(0, 1000) - 500;
         applyStimulus($urandom_range(0, 3) != 0, acc);
      end
      clr_ovf = 1'b0; out_ready = 1'b1;
      idle(20);
      checkOutput("final level", fifo_level, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/conv_postproc.md
Name: conv_postproc

Overview:
- Stage directly downstream of the 3x3 systolic convolution engine.
- Takes the raw 32-bit signed accumulator stream (one result per accepted input pixel) and discards border results from the line-buffer warm-up.
- Requantises each kept result (round, arithmetic shift, optional ReLU, saturate to 8 bits) and buffers it in a FIFO.
- Presents results to the next consumer over a ready/valid handshake with an end-of-frame tag.

Parameters:
- IMG_WIDTH, 32, pixels per input row; must be >= 3.
- IMG_HEIGHT, 32, rows per input frame; must be >= 3.
- ACC_WIDTH, 32, width of the incoming accumulator.
- FIFO_DEPTH, 16, output FIFO entries; power of two, >= 4.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset; asynchronous, active-low.
- in_valid, input, 1, accumulator result valid; no backpressure to upstream.
- in_acc, input, ACC_WIDTH, signed convolution result.
- cfg_shift, input, 5, right-shift amount 0..31.
- cfg_relu, input, 1, 1 = clamp negatives to 0 and output unsigned 0..255; 0 = output signed int8.
- clr_ovf, input, 1, synchronous clear of the overflow flag.
- out_valid, output, 1, FIFO head valid.
- out_ready, input, 1, consumer accepts the head.
- out_data, output, 8, requantised pixel.
- out_last, output, 1, head is the final pixel of the frame.
- fifo_level, output, log2(FIFO_DEPTH)+1, current occupancy.
- overflow, output, 1, sticky: a kept sample was dropped because the FIFO was full.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, fifo_level=0, overflow=0. Counters, pipeline valids and FIFO pointers are 0. Reset mid-frame discards all in-flight and buffered data.
- Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1):
  - Advance only on in_valid.
  - col wraps to 0 and increments row; row wraps to 0 after IMG_HEIGHT-1, starting the next frame.
- Keep rule: sample kept iff row>=2 and col>=2. Output frame is (IMG_WIDTH-2)x(IMG_HEIGHT-2). Dropped samples have no effect except advancing the counters.
- Config sampling: cfg_shift and cfg_relu are latched into active registers on the in_valid with row=0, col=0. Mid-frame changes do not apply until the next frame. Reset loads the active registers with shift=0, relu=0.
- Pipeline stage 1 (register):
  - t = in_acc + (shift>0 ? 1<<(shift-1) : 0), computed at ACC_WIDTH+1 bits signed, no wrap.
  - t is then arithmetic right shifted by shift.
  - Carries keep, last (row=H-1 and col=W-1) and valid.
- Pipeline stage 2 (register, FIFO write):
  - relu=1: value <0 -> 0, >255 -> 255, else value.
  - relu=0: saturate to -128..127, two's complement on out_data.
  - Writes {last, data} to the FIFO if keep.
- Latency: kept in_valid at cycle N -> FIFO write at end of N+2 -> out_valid high at N+3 when the FIFO was empty (first-word fall-through).
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_data/out_last hold stable while out_valid=1 and out_ready=0.
  - out_valid = (fifo_level != 0).
- Full: a write with the FIFO full and no pop in the same cycle drops the sample and sets overflow. Full plus simultaneous pop accepts the write; level is unchanged.
- Empty: pop is ignored when out_valid=0.
- Simultaneous push and pop at any level leaves the level unchanged.
- overflow clears on clr_ovf. If clr_ovf coincides with a new drop, overflow remains set.

Optional Feature:
- CONV_POSTPROC_STATS_EN defined:
  - Adds output sat_count (16 bits): counts kept samples whose value was clamped in stage 2 (ReLU zeroing counts).
  - Saturates at 0xFFFF.
  - Cleared to 0 at reset and on each frame-start config latch.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- IMG 4x4, shift=0, relu=1, out_ready=1, in_acc=0..15 -> 4 outputs: 10, 11, 14, 15. out_last=1 only on 15. First out_valid exactly 3 cycles after the in_valid carrying 10.
- shift=4, relu=0, kept inputs 24, -24, 4000, -5000 -> 2, -1 (0xFF), 127 (0x7F), -128 (0x80). Rounding check: (-24+8)>>>4 = -1.
- relu=1, shift=0, kept inputs -7, 300, 255 -> 0, 255, 255. With STATS_EN, sat_count=2.
- FIFO_DEPTH=4, IMG 8x8, out_ready=0 for the whole frame -> level saturates at 4 and overflow=1. First 4 kept values are intact in order after out_ready=1. clr_ovf -> overflow=0.
- Full FIFO with out_ready=1 in the write cycle -> no drop, level stays 4, overflow stays 0.
- cfg_shift changed 0->3 mid-frame -> the rest of the frame uses shift 0; the next frame uses 3. Assert rst_n low mid-frame -> out_valid=0, level=0, next frame restarts at row 0, col 0.
